// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch sequencer: a LOAD state gives the memory port to the boot loader
// for writes, and a RUN state streams {pc, instr} to decode with stall and redirect handling.
module imem_fetch_ctrl #(
    parameter int unsigned MEM_BYTES = 128,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        load_done,
    input  logic        load_start,
    output logic        load_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    // Word-aligned and wrapped to the memory size in a single AND.
    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 4);

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    state_e      r_state, w_state_d;
    logic [31:0] r_pc, w_pc_d;
    logic [31:0] r_inflight_pc, w_inflight_pc_d;
    logic [31:0] r_fetch_count, w_fetch_count_d;
    logic        r_inflight, w_inflight_d;
    logic        r_misalign, w_misalign_d;

    logic [31:0] w_target;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic        w_mem_we;
    logic        w_fetch_valid;
    logic        w_load_ready;

    assign w_target = redirect_pc & ADDR_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StLoad;
            r_pc          <= RESET_PC & ADDR_MASK;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_misalign    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            r_inflight    <= w_inflight_d;
            r_inflight_pc <= w_inflight_pc_d;
            r_misalign    <= w_misalign_d;
            r_fetch_count <= w_fetch_count_d;
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_pc_d          = r_pc;
        w_inflight_d    = r_inflight;
        w_inflight_pc_d = r_inflight_pc;
        w_misalign_d    = r_misalign;
        w_fetch_count_d = r_fetch_count;
        w_mem_addr      = '0;
        w_mem_wdata     = '0;
        w_mem_we        = 1'b0;
        w_fetch_valid   = 1'b0;
        w_load_ready    = 1'b0;

        unique case (r_state)
            StLoad: begin
                w_load_ready = 1'b1;
                w_mem_we     = load_valid;
                w_mem_addr   = load_addr & ADDR_MASK;
                w_mem_wdata  = load_data;
                if (load_done) begin
                    w_state_d    = StRun;
                    w_pc_d       = RESET_PC & ADDR_MASK;
                    w_inflight_d = 1'b0;
                end
            end
            StRun: begin
                w_fetch_valid = r_inflight & ~redirect & ~load_start;
                if (load_start) begin
                    w_state_d    = StLoad;
                    w_inflight_d = 1'b0;
                end else if (redirect) begin
                    w_mem_addr      = w_target;
                    w_inflight_d    = 1'b1;
                    w_inflight_pc_d = w_target;
                    w_pc_d          = (w_target + 32'd4) & ADDR_MASK;
                    if (redirect_pc[1:0] != 2'b00) begin
                        w_misalign_d = 1'b1;
                    end
                end else if (stall) begin
                    // Re-reading the presented word keeps mem_rdata stable across the stall.
                    w_mem_addr = r_inflight_pc;
                end else begin
                    w_mem_addr      = r_pc;
                    w_inflight_d    = 1'b1;
                    w_inflight_pc_d = r_pc;
                    w_pc_d          = (r_pc + 32'd4) & ADDR_MASK;
                end
                if (w_fetch_valid && !stall) begin
                    w_fetch_count_d = r_fetch_count + 32'd1;
                end
            end
            default: begin
                w_state_d = StLoad;
            end
        endcase
    end

    // Port outputs are forced to idle while reset is held, whatever the loader drives.
    assign mem_addr     = rst_n ? w_mem_addr : '0;
    assign mem_wdata    = rst_n ? w_mem_wdata : '0;
    assign mem_we       = rst_n & w_mem_we;
    assign fetch_valid  = rst_n & w_fetch_valid;
    assign load_ready   = w_load_ready;
    assign fetch_pc     = r_inflight_pc;
    assign fetch_instr  = mem_rdata;
    assign misalign_err = r_misalign;
    assign fetch_count  = r_fetch_count;

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer and port arbiter for the byte-addressed, little-endian instruction memory. The memory returns the word at mem_addr one posedge after it is presented. The block owns the PC and gives the memory port to a boot loader (writes) or to the CPU fetch path (reads), never both. It delivers {pc, instruction} to decode with stall and branch-redirect support, and sits between the instruction memory and the decode stage.

Parameters:
MEM_BYTES, 128, instruction memory size in bytes (power of two, multiple of 4); all addresses wrap modulo MEM_BYTES.
RESET_PC, 32'h0000_0000, first fetch address after a load completes (word-aligned, < MEM_BYTES).

Ports:
clk  input  1  clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  loader write request (LOAD state only)
load_addr  input  32  loader byte address; bits[1:0] ignored
load_data  input  32  loader write word
load_done  input  1  loader finished; start fetching
load_start  input  1  return to LOAD from RUN
load_ready  output  1  high only in LOAD
stall  input  1  decode cannot accept this cycle
redirect  input  1  branch/jump taken; refetch from redirect_pc
redirect_pc  input  32  redirect target byte address
mem_addr  output  32  memory address, combinational from state
mem_we  output  1  memory write strobe (combinational)
mem_wdata  output  32  memory write word
mem_rdata  input  32  memory read word (registered in memory)
fetch_valid  output  1  fetch_instr/fetch_pc valid
fetch_pc  output  32  byte address of fetch_instr
fetch_instr  output  32  = mem_rdata, passed through
misalign_err  output  1  sticky: redirect_pc[1:0] != 0 seen
fetch_count  output  32  instructions accepted by decode

Behaviour:
- Reset (async, rst_n=0): state=LOAD, pc=RESET_PC, inflight=0, inflight_pc=0, misalign_err=0, fetch_count=0. Outputs: load_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, fetch_valid=0. Reset mid-load or mid-fetch drops the in-flight request with no delivery.
- States: LOAD, RUN. The whole design is two states plus the inflight bit.
- LOAD: mem_we=load_valid, mem_addr={load_addr[31:2],2'b00} mod MEM_BYTES, mem_wdata=load_data, fetch_valid=0.
  - load_done=1 with load_valid=1 in the same cycle: the write completes that cycle, then the state changes.
  - load_done -> RUN next cycle; pc=RESET_PC, inflight=0.
  - stall, redirect and load_start are ignored in LOAD.
- RUN: mem_we=0, load_ready=0, fetch_valid=inflight & ~redirect.
- RUN priority per cycle: load_start > redirect > stall > normal.
  - normal: mem_addr=pc, inflight<=1, inflight_pc<=pc, pc<=(pc+4) mod MEM_BYTES. On the first RUN cycle, RESET_PC is issued and fetch_valid=0. The instruction for an address is visible one cycle after issue.
  - stall=1: mem_addr=inflight_pc, which re-reads the same word so mem_rdata holds; pc and inflight_pc hold; fetch_valid/fetch_pc/fetch_instr stay stable. With inflight=0, nothing is issued and pc holds.
  - redirect=1 (overrides stall): the current fetch is squashed (fetch_valid=0 this cycle). t = redirect_pc with bits[1:0] forced 0, mod MEM_BYTES. mem_addr=t, inflight_pc<=t, inflight<=1, pc<=t+4 mod MEM_BYTES. If redirect_pc[1:0]!=0, misalign_err<=1 (sticky until reset).
  - load_start=1: the in-flight request is discarded, fetch_valid=0 this cycle, LOAD next cycle.
- fetch_count increments when fetch_valid & ~stall & ~redirect; it wraps at 2^32 and is not cleared by LOAD.
- Wrap: pc at MEM_BYTES-4 advances to 0. mem_addr bits above log2(MEM_BYTES) are always 0, so the memory never reads past its last byte.
- fetch_pc=inflight_pc; fetch_instr=mem_rdata (no extra register, no extra latency).

Test Plan:
- Boot load: reset, then write 32'h34020026 @4, 32'h34030034 @8 (addr 9 also targets 8), then load_done. Expect mem_we pulses with mem_addr=4, 8, 8. load_ready drops the cycle after load_done. First fetch_valid two cycles after load_done with fetch_pc=0.
- Sequential fetch: no stall. Expect fetch_pc 0,4,8,12 on consecutive cycles, fetch_instr matching loaded words, and fetch_count=4 after four accepted cycles.
- Stall: assert stall for 3 cycles while fetch_pc=8. Expect fetch_valid=1, fetch_pc=8, instr 32'h34030034 held, mem_addr=8, fetch_count unchanged. Release gives fetch_pc=12 next cycle.
- Redirect with simultaneous stall: redirect_pc=32'h4 at fetch_pc=16. Expect fetch_valid=0 that cycle, then fetch_pc=4, 8. Redirect_pc=32'h6 sets misalign_err=1 and fetches from 4.
- Wrap, MEM_BYTES=128: redirect to 124. Expect fetch_pc 124 then 0; mem_addr never exceeds 124.
- Reset mid-RUN and load_start: drop rst_n while fetch_valid=1. Expect all outputs at reset values immediately. In RUN, load_start gives fetch_valid=0, load_ready=1 next cycle, and ignores stall/redirect.
